// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller around EX: operand forwarding selects, load-use and
// flag stalls, taken-branch flushes, a MEM/WB destination scoreboard and
// saturating stall/flush counters.

// Per-source comparator: does this ID source hit the EX or MEM destination.
module hazard_src #(
  parameter int ZERO_REG = 31
) (
  input  logic [4:0] src,
  input  logic       use_src,
  input  logic [4:0] ex_rd,
  input  logic       ex_we,
  input  logic [4:0] mem_rd,
  input  logic       mem_we,
  output logic       ex_hit,
  output logic       mem_hit
);
  logic live;
  // XZR never carries a dependency
  assign live    = use_src && (src != 5'(ZERO_REG));
  assign ex_hit  = live && ex_we  && (ex_rd  == src);
  assign mem_hit = live && mem_we && (mem_rd == src);
endmodule

module pipeline_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_uses_flags,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic             ex_setflag,
  input  logic             ex_pc_select,
  output logic             stall_if,
  output logic             bubble_ex,
  output logic             flush_ifid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int NSRC = 2;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
  } sb_ent_t;

  sb_ent_t sb_mem, sb_wb;

  logic                      ex_we;
  logic [NSRC-1:0][4:0]      src;
  logic [NSRC-1:0]           src_use;
  logic [NSRC-1:0]           ex_hit, mem_hit;
  logic [NSRC-1:0][1:0]      fwd;
  logic                      load_use, flag_stall, br_taken;

  assign ex_we   = ex_valid && ex_regwrite;
  assign src     = {id_rm, id_rn};
  assign src_use = {id_uses_rm, id_uses_rn};

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_src
      hazard_src #(.ZERO_REG(ZERO_REG)) u_src (
        .src     (src[g]),
        .use_src (src_use[g]),
        .ex_rd   (ex_rd),
        .ex_we   (ex_we),
        .mem_rd  (sb_mem.rd),
        .mem_we  (sb_mem.we),
        .ex_hit  (ex_hit[g]),
        .mem_hit (mem_hit[g])
      );
      // EX result is newer than MEM, so it wins; no WB path (regfile write-before-read)
      assign fwd[g] = !id_valid   ? 2'd0 :
                      ex_hit[g]   ? 2'd1 :
                      mem_hit[g]  ? 2'd2 : 2'd0;
    end
  endgenerate

  assign fwd_a = fwd[0];
  assign fwd_b = fwd[1];

  // Stall / flush decode; a taken branch overrides any stall so the PC takes the target
  always_comb begin
    load_use   = id_valid && ex_memtoreg && (|ex_hit);
    flag_stall = id_valid && id_uses_flags && ex_valid && ex_setflag;
    br_taken   = ex_valid && ex_pc_select;
    stall_if   = (load_use || flag_stall) && !br_taken;
    bubble_ex  = load_use || flag_stall || br_taken;
    flush_ifid = br_taken;
  end

  // Destination scoreboard: EX -> MEM -> WB
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_mem <= '0;
      sb_wb  <= '0;
    end else begin
      sb_mem <= '{rd: ex_rd, we: ex_we};
      sb_wb  <= sb_mem;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_if && !(&stall_count))   stall_count <= stall_count + 1'b1;
      if (flush_ifid && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expected-output queue and
// a reference model of the saturating counters.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic id_valid = 0, id_uses_rn = 0, id_uses_rm = 0, id_uses_flags = 0;
  logic [4:0] id_rn = 0, id_rm = 0, ex_rd = 0;
  logic ex_valid = 0, ex_regwrite = 0, ex_memtoreg = 0, ex_setflag = 0, ex_pc_select = 0;
  logic stall_if, bubble_ex, flush_ifid;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count, flush_count;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_uses_flags(id_uses_flags),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_setflag(ex_setflag), .ex_pc_select(ex_pc_select),
    .stall_if(stall_if), .bubble_ex(bubble_ex), .flush_ifid(flush_ifid),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       stall, bubble, flush;
    logic [1:0] fa, fb;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  logic [CNT_W-1:0] m_sc = '0, m_fc = '0;

  function automatic exp_t E(logic s, logic b, logic f, logic [1:0] a, logic [1:0] bb);
    exp_t e;
    e = '{stall: s, bubble: b, flush: f, fa: a, fb: bb};
    return e;
  endfunction

  task automatic set_id(logic v, logic [4:0] rn, logic [4:0] rm, logic urn, logic urm, logic uf);
    id_valid = v; id_rn = rn; id_rm = rm; id_uses_rn = urn; id_uses_rm = urm; id_uses_flags = uf;
  endtask

  task automatic set_ex(logic v, logic [4:0] rd, logic rw, logic m2r, logic sf, logic pcs);
    ex_valid = v; ex_rd = rd; ex_regwrite = rw; ex_memtoreg = m2r; ex_setflag = sf; ex_pc_select = pcs;
  endtask

  // One clock: queue expectation, compare combinational outputs, advance the
  // counter model across the edge, then compare counters.
  task automatic cyc(string tag, logic rst, logic chk, exp_t e);
    exp_t want, got;
    reset = rst;
    if (chk) q.push_back(e);
    #2;
    if (chk) begin
      want = q.pop_front();
      got  = '{stall: stall_if, bubble: bubble_ex, flush: flush_ifid, fa: fwd_a, fb: fwd_b};
      checks++;
      assert (got === want) else begin
        failures++;
        $error("FAIL %s outs got=%b required=%b", tag, got, want);
      end
    end
    if (rst) begin
      m_sc = '0; m_fc = '0;
    end else begin
      if (e.stall && m_sc != '1) m_sc = m_sc + 1'b1;
      if (e.flush && m_fc != '1) m_fc = m_fc + 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    assert ({stall_count, flush_count} === {m_sc, m_fc}) else begin
      failures++;
      $error("FAIL %s counters got=%0d/%0d required=%0d/%0d", tag,
             stall_count, flush_count, m_sc, m_fc);
    end
  endtask

  exp_t Z;

  initial begin
    Z = E(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    // reset with arbitrary activity
    set_id(1, 5, 5, 1, 1, 1); set_ex(1, 5, 1, 1, 1, 1);
    cyc("rst0", 1, 0, Z);
    cyc("rst1", 1, 0, Z);
    set_id(0, 0, 0, 0, 0, 0); set_ex(0, 0, 0, 0, 0, 0);
    cyc("idle0", 0, 1, Z);
    cyc("idle1", 0, 1, Z);

    // EX forward then MEM forward
    set_id(1, 3, 0, 1, 0, 0); set_ex(1, 3, 1, 0, 0, 0);
    cyc("fwd_ex_a", 0, 1, E(0, 0, 0, 1, 0));
    set_id(1, 0, 3, 0, 1, 0); set_ex(1, 8, 0, 0, 0, 0);
    cyc("fwd_mem_b", 0, 1, E(0, 0, 0, 0, 2));

    // load-use: one stall, then MEM forward from the load
    set_id(1, 5, 0, 1, 0, 0); set_ex(1, 5, 1, 1, 0, 0);
    cyc("lduse", 0, 1, E(1, 1, 0, 1, 0));
    set_ex(0, 0, 0, 0, 0, 0);
    cyc("lduse_after", 0, 1, E(0, 0, 0, 2, 0));

    // XZR never hazards, even as load or from MEM
    set_id(1, 31, 31, 1, 1, 0); set_ex(1, 31, 1, 0, 0, 0);
    cyc("xzr", 0, 1, Z);
    set_ex(1, 31, 1, 1, 0, 0);
    cyc("xzr_ld", 0, 1, Z);

    // EX beats MEM for the same register; both operands
    set_id(1, 9, 0, 1, 1, 0); set_ex(1, 9, 1, 0, 0, 0);
    cyc("pri_prep", 0, 1, E(0, 0, 0, 1, 0));
    set_id(1, 9, 9, 1, 1, 0); set_ex(1, 9, 1, 0, 0, 0);
    cyc("pri_ex_mem", 0, 1, E(0, 0, 0, 1, 1));

    // source not used -> no forward; id_valid low gates forwarding
    set_id(1, 4, 4, 0, 0, 0); set_ex(1, 4, 1, 0, 0, 0);
    cyc("unused", 0, 1, Z);
    set_id(0, 4, 4, 1, 1, 0); set_ex(1, 4, 1, 0, 0, 0);
    cyc("id_inv", 0, 1, Z);

    // flag stall
    set_id(1, 0, 0, 0, 0, 1); set_ex(1, 0, 0, 0, 1, 0);
    cyc("flag", 0, 1, E(1, 1, 0, 0, 0));
    set_ex(0, 0, 0, 0, 0, 0);
    cyc("flag_after", 0, 1, Z);

    // load-use + flag together: one stall
    set_id(1, 6, 0, 1, 0, 1); set_ex(1, 6, 1, 1, 1, 0);
    cyc("combo", 0, 1, E(1, 1, 0, 1, 0));

    // taken branch beats load-use
    set_id(1, 7, 0, 1, 0, 0); set_ex(1, 7, 1, 1, 0, 1);
    cyc("branch", 0, 1, E(0, 1, 1, 1, 0));
    set_id(0, 0, 0, 0, 0, 0); set_ex(0, 0, 0, 0, 0, 0);
    cyc("br_after", 0, 1, Z);

    // stall counter saturation: 2^CNT_W + 3 stalled cycles
    set_id(1, 0, 0, 0, 0, 1); set_ex(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) cyc("sat", 0, 1, E(1, 1, 0, 0, 0));
    checks++;
    assert (stall_count === 4'hF) else begin
      failures++;
      $error("FAIL sat_final got=%0d required=15", stall_count);
    end

    // reset mid-stall
    cyc("rst_mid", 1, 0, Z);
    set_id(0, 0, 0, 0, 0, 0); set_ex(0, 0, 0, 0, 0, 0);
    cyc("post_rst", 0, 1, Z);
    // scoreboard invalid after reset: MEM entry must not forward
    set_id(1, 0, 0, 1, 0, 0); set_ex(0, 0, 0, 0, 0, 0);
    cyc("sb_clear", 0, 1, Z);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline around the EX stage. It compares the instruction in ID against in-flight destinations in EX and MEM and produces three kinds of output: forwarding selects, load-use and flag stalls, and wrong-path flushes on a taken branch resolved in EX. It keeps its own MEM/WB destination scoreboard and saturating stall/flush performance counters.

Parameters:
CNT_W, 16, width of stall_count and flush_count
ZERO_REG, 31, register index that never creates a hazard (XZR)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high
id_valid  input  1  ID stage holds a real instruction
id_rn  input  5  ID source register A
id_rm  input  5  ID source register B (Rm, or Rt for STUR/CBZ)
id_uses_rn  input  1  ID reads Rn
id_uses_rm  input  1  ID reads Rm/Rt
id_uses_flags  input  1  ID is B.cond (reads flags)
ex_valid  input  1  EX holds a real instruction
ex_rd  input  5  EX destination
ex_regwrite  input  1  EX writes register file
ex_memtoreg  input  1  EX is a load
ex_setflag  input  1  EX writes flags
ex_pc_select  input  1  EX branch taken (conditional or unconditional)
stall_if  output  1  hold PC and IF/ID register
bubble_ex  output  1  load NOP (all control 0) into ID/EX
flush_ifid  output  1  replace IF/ID contents with NOP
fwd_a  output  2  operand A source: 0 regfile, 1 EX result, 2 MEM result
fwd_b  output  2  operand B source, same encoding
stall_count  output  CNT_W  cycles stalled, saturating
flush_count  output  CNT_W  taken-branch flushes, saturating

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high.
- Reset state: scoreboard entries invalid; stall_count and flush_count = 0. With id_valid = ex_valid = 0, all outputs are 0.
- Output timing: stall_if, bubble_ex, flush_ifid, fwd_a and fwd_b are combinational from the current inputs and the registered scoreboard. They take effect at the next posedge.
- Scoreboard: one MEM entry {mem_rd, mem_we} and one WB entry {wb_rd, wb_we}. Each posedge: MEM <= {ex_rd, ex_valid & ex_regwrite}; WB <= MEM.
- WB forwarding: none. The register file writes before it reads, so WB needs no forwarding. The WB entry is kept only for visibility in verification.
- Match definition: a source matches a stage when that source is used, the stage's write-enable is set, the stage's rd equals the source, and the source != ZERO_REG.
- Forwarding priority: EX match gives 1; else MEM match gives 2; else 0. An EX match counts only when ex_valid & ex_regwrite.
- Forwarding gating: when id_valid = 0, fwd_a = fwd_b = 0.
- Load-use stall: a match against EX while ex_memtoreg = 1 asserts stall_if = 1 and bubble_ex = 1 for one cycle. On the next cycle the load is in MEM and the select becomes fwd = 2; no second stall.
- Flag stall: id_valid & id_uses_flags & ex_valid & ex_setflag asserts stall_if = 1 and bubble_ex = 1 for one cycle. The flagfile then holds the new flags when B.cond reaches EX.
- Taken branch: ex_valid & ex_pc_select asserts flush_ifid = 1 and bubble_ex = 1, with stall_if = 0 so the PC loads the target. This kills the two wrong-path instructions.
- Priority: taken branch beats any stall. When both conditions are true, stall_if = 0 and the flush is performed.
- Combined stalls: load-use and flag stall in the same cycle produce a single one-cycle stall.
- stall_count: increments on every cycle with stall_if = 1. It saturates at all-ones and never wraps.
- flush_count: increments on every cycle with flush_ifid = 1. It saturates at all-ones and never wraps.
- Reset mid-stall: the next cycle has all outputs at their reset values and the scoreboard invalid. No pending stall survives reset.
- Bubble visibility: the inserted bubble arrives as ex_valid = 0 on the following cycle, so it never matches and never writes the scoreboard.

Test Plan:
- Reset held for 2 cycles with arbitrary inputs -> all outputs 0 during the cycle after reset drops. Counters stay 0 while id_valid = ex_valid = 0.
- EX ADD X3 (ex_rd = 3, regwrite = 1) with ID reading id_rn = 3 -> fwd_a = 1, no stall. Next cycle, with EX holding a non-writing instruction and ID reading rm = 3 -> fwd_b = 2.
- EX LDUR X5 (memtoreg = 1, rd = 5) with ID reading rn = 5 -> stall_if = bubble_ex = 1 for exactly 1 cycle and stall_count = 1. Next cycle: fwd_a = 2, stall_if = 0.
- EX writes X31 with ID reading rn = 31 -> fwd_a = 0, no stall. Repeat with memtoreg = 1 -> still no stall.
- EX SUBS (setflag = 1) with ID B.LT (id_uses_flags = 1) -> one-cycle stall. A taken branch (ex_pc_select = 1) while ID has a load-use match -> flush_ifid = bubble_ex = 1, stall_if = 0, flush_count = 1, stall_count unchanged.
- Force stall_if high for 2^CNT_W + 3 cycles (using CNT_W = 4 in the bench) -> stall_count stops at 15 with no wrap. Assert reset -> stall_count = 0 on the next cycle.
